demux_1x8_deser: RTL and testbench
==================================

# demux_1x8_deser

Sequential 1-to-8 demultiplexing deserializer: the receive end of the team's 8:1 bit-select serial path. A 3-bit internal select counter steers each accepted serial bit to slot `dout[idx]`, so bit k lands where select value k picks it on the transmit side. A full word is handed to a one-entry holding register with a valid/ready handshake. The block sits between a serial bit source and any parallel byte consumer.

## Interface
- `N`, default 8: word width; the number of demux outputs.
- `SEL_W`, default 3: select/index width; equals `$clog2(N)`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `din` in 1: serial data bit.
- `din_valid` in 1: `din` is valid this cycle.
- `din_ready` out 1: block accepts `din` this cycle.
- `flush` in 1: synchronous clear of the partial word in assembly.
- `dout` out N: completed word; bit k holds the k-th accepted bit.
- `out_valid` out 1: `dout` holds an unconsumed word.
- `out_ready` in 1: consumer accepts `dout`.
- `bit_idx` out SEL_W: current demux select; the slot the next accepted bit will fill.
- `overrun` out 1: sticky error flag, cleared only by reset.

## Operation
- **Accept:** a bit is accepted when `din_valid && din_ready` at the rising edge. It is written to assembly register `asm[bit_idx]`, and `bit_idx` increments by 1.
- **Word completion:** an accept with `bit_idx == N-1` completes the word.
  - Holding register loads `{din, asm[N-2:0]}`; the assembly register does not need clearing.
  - `bit_idx` wraps to 0.
  - `out_valid` is set.
- **Consume:** `out_valid && out_ready` clears `out_valid`, unless a word completes in the same cycle. In that case the new word loads and `out_valid` stays 1.
- **Backpressure:** `din_ready = !(out_valid && !out_ready && bit_idx == N-1)`. Bits 0..N-2 of the next word are always accepted while the hold is full. Only the completing bit stalls.
- **Overrun:** set if a word completes while the hold is full and is not being consumed. This is unreachable when the source obeys `din_ready`; it exists as a protocol checker. In that case the hold keeps its old word and the completing bit is dropped.
- **Flush:** sets `bit_idx` to 0 and discards the partial word.
  - Flush has priority over a simultaneous `din` accept; that bit is dropped.
  - Flush does not affect the hold, `out_valid`, or `overrun`.
  - While `flush` is high, `din_ready` may be 1, but nothing is accepted.
- **Index arithmetic:** `bit_idx` is modulo N, unsigned, SEL_W bits. N must be a power of two.

## Timing
- **Reset values:**
  - `dout` = 0, `out_valid` = 0, `overrun` = 0, `bit_idx` = 0.
  - `asm` = 0, `din_ready` = 1.
- **Reset mid-word:** discards the partial word and the hold word. The next accepted bit goes to slot 0.
- **Latency:** `out_valid` rises on the edge that accepts bit N-1; `dout` is visible the cycle after the last bit is presented.
- **Throughput:** one bit per cycle with `out_ready` held high; no bubbles between words.
- **Outputs:**
  - All outputs are registered except `din_ready`.
  - `din_ready` is combinational from `out_valid`, `out_ready` and `bit_idx`; there is no path from `din`.
- **Handshake:** valid/ready, AXI-stream rules on both sides. The consumer may hold `out_ready` low indefinitely; `dout` stays stable while `out_valid && !out_ready`.

## Structure
- **Shared package (`demux_pkg`):** holds `N`, `SEL_W`, and the word typedef `word_t` (N bits). These are shared with the serializer side so both ends agree on width and bit order (LSB first).
- **Sub-module:** one natural split, `deser_hold_reg`: the one-entry valid/ready holding stage (load, consume, stall, overrun). It is reusable for other parallel outputs.
- **Top level:** contains the index counter, assembly register, flush logic and `din_ready`.
- **FSM:** none beyond the counter and the valid flag.

## Test plan
1. **Single word:** reset, then 8 bits of 0xA5 LSB first with `out_ready` = 1 → `out_valid` high for one cycle after bit 7 is accepted, `dout` = 0xA5, `bit_idx` back to 0.
2. **Back-to-back:** 0x01, 0x80, 0xFF, 0x00 streamed with `din_valid` and `out_ready` constant 1 → four words on consecutive 8-cycle boundaries, no `din_ready` deassertion, `overrun` = 0.
3. **Backpressure:** `out_ready` = 0 while two words (0x3C, 0xC3) are sent →
   - `dout` holds 0x3C.
   - `din_ready` drops only when `bit_idx` = 7 of the second word.
   - Raising `out_ready` delivers 0x3C, then 0xC3.
4. **Flush:** 3 bits sent, then `flush` pulsed together with a valid bit, then 0x5A →
   - Only 0x5A is output.
   - `bit_idx` = 0 after the flush.
   - The concurrent bit is dropped.
5. **Reset mid-operation:** `rst_n` low after 5 bits with a word held → all outputs at reset values on the next edge; a following 0x96 is received correctly.
6. **Loopback:** a counter-driven 8:1 select serializer feeds 256 words of random data → every received word equals the transmitted word, `overrun` never set.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 8:1 bit-select serial path. The serializer and the
// deserializer both import this so they agree on word width and on bit order:
// bit k of a word travels in serial slot k, LSB first.
package demux_pkg;

  localparam int unsigned N     = 8;           // word width / number of demux slots
  localparam int unsigned SEL_W = $clog2(N);   // select / index width

  typedef logic [N-1:0] word_t;

endpackage

// File: rtl/deser_hold_reg.sv
// One-entry valid/ready holding stage for a parallel word.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   load      in   a new word is offered this cycle
//   load_data in   W  word to capture
//   ready     in   downstream accepts data this cycle
//   data      out  W  held word, stable while valid && !ready
//   valid     out  data holds an unconsumed word
//   overrun   out  sticky: a load arrived while full and not draining
module deser_hold_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         overrun
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;
  logic         stalled;

  // Full and nobody draining this cycle: a load here has nowhere to go.
  assign stalled = valid_q && !ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load) begin
      if (stalled) begin
        // Keep the old word; the incoming one is lost.
        ovr_d = 1'b1;
      end else begin
        // Covers both empty and simultaneous consume-and-reload.
        data_d  = load_data;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/demux_1x8_deser.sv
// Sequential 1-to-N demultiplexing deserializer. A select counter steers each
// accepted serial bit into slot bit_idx of an assembly register; the bit that
// fills slot N-1 completes the word, which moves into a one-entry hold stage.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   din        in   serial data bit
//   din_valid  in   din is valid this cycle
//   din_ready  out  din is accepted this cycle (combinational, no path from din)
//   flush      in   drop the partial word and restart at slot 0
//   dout       out  N  completed word, bit k = k-th accepted bit
//   out_valid  out  dout holds an unconsumed word
//   out_ready  in   consumer accepts dout
//   bit_idx    out  SEL_W  slot the next accepted bit fills
//   overrun    out  sticky protocol-violation flag
module demux_1x8_deser #(
  parameter int unsigned N     = demux_pkg::N,
  parameter int unsigned SEL_W = demux_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic [N-1:0]     dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] bit_idx,
  output logic             overrun
);

  import demux_pkg::*;

  // N must be a power of two so the index wraps naturally at SEL_W bits.
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(N - 1);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N-1:0]     asm_q, asm_d;
  logic             last_slot;
  logic             accept;
  logic             complete;

  assign last_slot = (idx_q == LastIdx);

  // Only the completing bit can stall: slots 0..N-2 never touch the hold.
  assign din_ready = !(out_valid && !out_ready && last_slot);

  // Flush wins over a concurrent bit, which is simply dropped.
  assign accept   = din_valid && din_ready && !flush;
  assign complete = accept && last_slot;

  always_comb begin
    asm_d = asm_q;
    idx_d = idx_q;
    if (flush) begin
      // Stale asm bits are harmless: every slot is rewritten before the next completion.
      idx_d = '0;
    end else if (accept) begin
      asm_d[idx_q] = din;
      idx_d        = idx_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

  deser_hold_reg #(
    .W (N)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .load_data ({din, asm_q[N-2:0]}),
    .ready     (out_ready),
    .data      (dout),
    .valid     (out_valid),
    .overrun   (overrun)
  );

  assign bit_idx = idx_q;

endmodule

// File: tb/tb_demux_1x8_deser.sv
module tb_demux_1x8_deser;
  import demux_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic             flush;
  word_t            dout;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] bit_idx;
  logic             overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux_1x8_deser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .flush     (flush),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bit_idx   (bit_idx),
    .overrun   (overrun)
  );

  typedef struct {
    word_t tx;
    word_t exp_dout;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input word_t w);
    for (int i = 0; i < 8; i++) begin
      din       = w[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " dout"}, 32'(dout), 32'h0);
    check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " overrun"}, 32'(overrun), 32'h0);
    check({tag, " bit_idx"}, 32'(bit_idx), 32'h0);
    check({tag, " din_ready"}, 32'(din_ready), 32'h1);
  endtask

  initial begin
    word_t a5;
    word_t c3;
    word_t tx;
    word_t cur;
    word_t q[$];
    int    sel;
    int    sent;
    int    got;
    logic  acc;
    logic  cons;
    logic  ovr_seen;

    vecs[0] = '{tx: 8'h01, exp_dout: 8'h01};
    vecs[1] = '{tx: 8'h80, exp_dout: 8'h80};
    vecs[2] = '{tx: 8'hFF, exp_dout: 8'hFF};
    vecs[3] = '{tx: 8'h00, exp_dout: 8'h00};

    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    rst_n = 1'b1;

    // 1. Single word, LSB first.
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      din = a5[i]; din_valid = 1'b1;
      check("single idx", 32'(bit_idx), 32'(i));
      tick();
    end
    din_valid = 1'b0;
    check("single out_valid", 32'(out_valid), 32'h1);
    check("single dout", 32'(dout), 32'hA5);
    check("single idx wrap", 32'(bit_idx), 32'h0);
    tick();
    check("single consumed", 32'(out_valid), 32'h0);

    // 2. Back-to-back words, din_valid and out_ready held high.
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 8; b++) begin
        din = vecs[w].tx[b]; din_valid = 1'b1;
        if (b == 0 && w > 0) begin
          check("b2b out_valid", 32'(out_valid), 32'h1);
          check("b2b dout", 32'(dout), 32'(vecs[w-1].exp_dout));
          check("b2b idx", 32'(bit_idx), 32'h0);
        end
        check("b2b din_ready", 32'(din_ready), 32'h1);
        tick();
      end
    end
    din_valid = 1'b0;
    check("b2b last out_valid", 32'(out_valid), 32'h1);
    check("b2b last dout", 32'(dout), 32'(vecs[3].exp_dout));
    check("b2b overrun", 32'(overrun), 32'h0);
    tick();

    // 3. Backpressure: two words, consumer stalled.
    out_ready = 1'b0;
    send_word(8'h3C);
    check("bp first valid", 32'(out_valid), 32'h1);
    check("bp first dout", 32'(dout), 32'h3C);
    c3 = 8'hC3;
    for (int i = 0; i < 7; i++) begin
      din = c3[i]; din_valid = 1'b1;
      #0;
      check("bp din_ready early", 32'(din_ready), 32'h1);
      tick();
    end
    din = c3[7]; din_valid = 1'b1;
    #0;
    check("bp din_ready stall", 32'(din_ready), 32'h0);
    tick();
    tick();
    check("bp stalled idx", 32'(bit_idx), 32'h7);
    check("bp stalled dout", 32'(dout), 32'h3C);
    check("bp stalled overrun", 32'(overrun), 32'h0);
    out_ready = 1'b1;
    #0;
    check("bp release din_ready", 32'(din_ready), 32'h1);
    check("bp deliver first", 32'(dout), 32'h3C);
    tick();
    din_valid = 1'b0;
    check("bp second valid", 32'(out_valid), 32'h1);
    check("bp second dout", 32'(dout), 32'hC3);
    check("bp second idx", 32'(bit_idx), 32'h0);
    tick();
    check("bp drained", 32'(out_valid), 32'h0);

    // 4. Flush with a concurrent valid bit.
    din = 1'b1; din_valid = 1'b1;
    tick(); tick(); tick();
    check("flush pre idx", 32'(bit_idx), 32'h3);
    flush = 1'b1; din = 1'b1;
    tick();
    flush = 1'b0; din_valid = 1'b0;
    check("flush idx", 32'(bit_idx), 32'h0);
    check("flush no word", 32'(out_valid), 32'h0);
    send_word(8'h5A);
    check("flush word valid", 32'(out_valid), 32'h1);
    check("flush word dout", 32'(dout), 32'h5A);
    tick();

    // 5. Reset mid-word with a word held.
    out_ready = 1'b0;
    send_word(8'h3C);
    for (int i = 0; i < 5; i++) begin
      din = 1'b1; din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    check("rst pre idx", 32'(bit_idx), 32'h5);
    check("rst pre held", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    tick();
    check_reset_state("midreset");
    rst_n = 1'b1; out_ready = 1'b1;
    send_word(8'h96);
    check("rst after dout", 32'(dout), 32'h96);
    check("rst after valid", 32'(out_valid), 32'h1);
    tick();

    // 6. Loopback from a counter-driven 8:1 serializer with random handshakes.
    sel = 0; sent = 0; got = 0; ovr_seen = 1'b0;
    tx = word_t'($urandom);
    din_valid = 1'b0;
    for (int cyc = 0; cyc < 20000 && got < 256; cyc++) begin
      if (!din_valid && sent < 256) din_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      din = tx[sel];
      #1;
      acc  = din_valid && din_ready;
      cons = out_valid && out_ready;
      cur  = dout;
      @(posedge clk);
      #1;
      ovr_seen = ovr_seen | overrun;
      if (cons) begin
        if (q.size() == 0) begin
          check("loopback spurious word", 32'(cur), 32'hFFFF_FFFF);
        end else begin
          check("loopback word", 32'(cur), 32'(q.pop_front()));
        end
        got++;
      end
      if (acc) begin
        din_valid = 1'b0;
        sel++;
        if (sel == 8) begin
          q.push_back(tx);
          sent++;
          sel = 0;
          tx = word_t'($urandom);
        end
      end
    end
    din_valid = 1'b0;
    check("loopback count", 32'(got), 32'd256);
    check("loopback overrun", 32'(ovr_seen), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
